// File: rtl/if_stage_pkg.sv
// Shared fetch/decode definitions: bubble instruction, fetch FSM states,
// branch opcode constants and the PC increment helper.
package if_stage_pkg;

  localparam logic [0:31] NOP_INSTR_DEF = 32'h5400_0000;
  localparam logic [0:5]  OPC_NOP       = 6'h15;
  localparam logic [0:5]  OPC_BEQZ      = 6'h04;
  localparam logic [0:5]  OPC_BNEZ      = 6'h05;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } if_state_t;

  // Wraps silently from 32'hFFFF_FFFC to zero.
  function automatic logic [0:31] pc_inc(input logic [0:31] a);
    return a + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem req/ack handshake and the IF/ID register,
// with stall hold, redirect handling and NOP bubble insertion.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [0:31] RESET_PC  = 32'h0000_0000,
  parameter logic [0:31] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall_ID,
  input  logic        redirect,
  input  logic [0:31] redirect_pc,
  output logic        imem_req,
  output logic [0:31] imem_addr,
  input  logic [0:31] imem_rdata,
  input  logic        imem_ack,
  output logic [0:31] instruction,
  output logic [0:31] if_id_pc_plus4,
  output logic        if_id_valid
);

  if_state_t   state_q, state_d;
  logic [0:31] pc_q, pc_d;
  logic [0:31] fetch_addr_q, fetch_addr_d;
  logic [0:31] hold_buf_q, hold_buf_d;
  logic [0:31] instr_q, instr_d;
  logic [0:31] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [0:31] target;
  logic [0:31] fetch_next;

  assign target     = redirect_pc & 32'hFFFF_FFFC;
  assign fetch_next = pc_inc(fetch_addr_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      fetch_addr_q <= RESET_PC;
      instr_q      <= NOP_INSTR;
      pc4_q        <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_addr_q <= fetch_addr_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    hold_buf_q <= hold_buf_d;
  end

  // A pending handshake is never abandoned: redirect without ack parks in S_DROP.
  always_comb begin
    state_d = state_q;
    if (redirect) begin
      if ((state_q != S_HOLD) && !imem_ack) state_d = S_DROP;
      else                                  state_d = S_REQ;
    end else begin
      case (state_q)
        S_REQ:   if (imem_ack && Stall_ID) state_d = S_HOLD;
        S_HOLD:  if (!Stall_ID)            state_d = S_REQ;
        S_DROP:  if (imem_ack)             state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end
  end

  always_comb begin
    pc_d         = pc_q;
    fetch_addr_d = fetch_addr_q;
    hold_buf_d   = hold_buf_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;
    if (redirect) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      pc_d    = target;
      if ((state_q == S_HOLD) || imem_ack) fetch_addr_d = target;
    end else begin
      case (state_q)
        S_REQ: begin
          if (imem_ack) begin
            if (!Stall_ID) begin
              instr_d      = imem_rdata;
              pc4_d        = fetch_next;
              valid_d      = 1'b1;
              pc_d         = fetch_next;
              fetch_addr_d = fetch_next;
            end else begin
              hold_buf_d = imem_rdata;
            end
          end else if (!Stall_ID) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (!Stall_ID) begin
            instr_d      = hold_buf_q;
            pc4_d        = fetch_next;
            valid_d      = 1'b1;
            pc_d         = fetch_next;
            fetch_addr_d = fetch_next;
          end
        end
        S_DROP: begin
          if (!Stall_ID) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
          end
          if (imem_ack) fetch_addr_d = pc_q;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    imem_req  = (state_q != S_HOLD);
    imem_addr = fetch_addr_q;
  end

  assign instruction    = instr_q;
  assign if_id_pc_plus4 = pc4_q;
  assign if_id_valid    = valid_q;

endmodule
